// File: rtl/dff_pipe_if.sv
// Bus bundle for dff_pipe: pipeline controls, input word and observed outputs.
// The master drives controls and data; the slave (the pipe) drives q/out_valid/count.
interface dff_pipe_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             out_valid;
  logic [CW-1:0]    count;

  modport master (
    output en,
    output flush,
    output in_valid,
    output d,
    input  q,
    input  out_valid,
    input  count
  );

  modport slave (
    input  en,
    input  flush,
    input  in_valid,
    input  d,
    output q,
    output out_valid,
    output count
  );
endinterface

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage enabled register pipeline with per-word
// valid flags, synchronous flush and a live occupancy count. Outputs come
// straight from registers (q optionally gated by the last-stage valid bit),
// so there is no combinational path from any input to any output.

// Invariant checker for the pipe: occupancy always matches the valid flags.
module dff_pipe_chk #(
  parameter int DEPTH = 3,
  parameter int CW    = 2
) (
  input logic             clk,
  input logic             reset,
  input logic [DEPTH-1:0] valid,
  input logic [CW-1:0]    count,
  input logic             out_valid
);
  a_count_popcount: assert property (@(posedge clk) disable iff (reset)
    int'(count) == $countones(valid));

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    int'(count) <= DEPTH);

  a_out_valid_last: assert property (@(posedge clk) disable iff (reset)
    out_valid == valid[DEPTH-1]);
endmodule

module dff_pipe #(
  parameter int               WIDTH        = 4,
  parameter int               DEPTH        = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter bit               GATE_INVALID = 1'b0
) (
  input logic        clk,
  input logic        reset,
  dff_pipe_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Next-state: flush clears, enable shifts, otherwise everything holds.
  // d/in_valid are only looked at on the enable path, so X there is harmless
  // while stalled.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = RESET_VALUE;
      end
      valid_d = '0;
      count_d = '0;
    end else if (bus.en) begin
      data_d[0]  = bus.d;
      valid_d[0] = bus.in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // Entry and exit on the same edge cancel; a full pipe only accepts a
      // word while one leaves, so the modulo arithmetic never escapes 0..DEPTH.
      count_d = count_q + CW'(bus.in_valid) - CW'(valid_q[DEPTH-1]);
    end else begin
      data_d  = data_q;
      valid_d = valid_q;
      count_d = count_q;
    end
  end

  // State registers; reset takes precedence over flush and enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VALUE;
      end
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Output view of the last stage, optionally masking data of invalid words.
  always_comb begin
    if (GATE_INVALID && !valid_q[DEPTH-1]) begin
      bus.q = RESET_VALUE;
    end else begin
      bus.q = data_q[DEPTH-1];
    end
  end

  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.count     = count_q;

  dff_pipe_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .valid     (valid_q),
    .count     (count_q),
    .out_valid (bus.out_valid)
  );
endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: two instances (ungated, RESET_VALUE=0 and gated,
// RESET_VALUE=C) share one stimulus stream. A queue model of the word history
// predicts every output each cycle; directed phases add literal expectations.
module tb_dff_pipe;
  localparam int WIDTH = 4;
  localparam int DEPTH = 3;
  localparam logic [3:0] RV_A = 4'h0;
  localparam logic [3:0] RV_B = 4'hC;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_a ();
  dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_b ();

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RV_A), .GATE_INVALID(1'b0))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));
  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RV_B), .GATE_INVALID(1'b1))
    dut_b (.clk(clk), .reset(reset), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the last DEPTH words pushed on enabled edges since the last clear.
  // Entry 0 is newest; the back entry is what sits in the output stage.
  typedef struct {
    logic [3:0] d;
    bit         v;
    bit         rf;  // filler from a clear: data is the instance's RESET_VALUE
  } ent_t;
  ent_t pipe_m[$];
  bit   known;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    foreach (pipe_m[i]) c += int'(pipe_m[i].v);
    return c;
  endfunction

  function automatic int m_q(input logic [3:0] rv, input bit gate);
    ent_t last = pipe_m[DEPTH-1];
    if (!last.v && gate) return int'(rv);
    return last.rf ? int'(rv) : int'(last.d);
  endfunction

  task automatic compare_all();
    if (known) begin
      check("a_q",     int'(if_a.q),         m_q(RV_A, 1'b0));
      check("a_valid", int'(if_a.out_valid), int'(pipe_m[DEPTH-1].v));
      check("a_count", int'(if_a.count),     m_count());
      check("b_q",     int'(if_b.q),         m_q(RV_B, 1'b1));
      check("b_valid", int'(if_b.out_valid), int'(pipe_m[DEPTH-1].v));
      check("b_count", int'(if_b.count),     m_count());
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare
  // at the next falling edge.
  task automatic cycle(input bit rst, input bit fl, input bit e, input bit iv,
                       input logic [3:0] dd);
    reset = rst;
    if_a.flush = fl; if_a.en = e; if_a.in_valid = iv; if_a.d = dd;
    if_b.flush = fl; if_b.en = e; if_b.in_valid = iv; if_b.d = dd;
    @(posedge clk);
    if (rst || fl) begin
      pipe_m.delete();
      for (int i = 0; i < DEPTH; i++) pipe_m.push_back('{4'h0, 1'b0, 1'b1});
      known = 1'b1;
    end else if (e && known) begin
      pipe_m.push_front('{dd, iv, 1'b0});
      void'(pipe_m.pop_back());
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    known = 1'b0;
    reset = 1'b0;
    if_a.flush = 1'b0; if_a.en = 1'b0; if_a.in_valid = 1'b0; if_a.d = 4'h0;
    if_b.flush = 1'b0; if_b.en = 1'b0; if_b.in_valid = 1'b0; if_b.d = 4'h0;
    @(negedge clk);

    // Reset with busy inputs, then one word whose latency is 3 edges.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'hF);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'hF);
    check("rst_q", int'(if_a.q), 0);
    check("rst_valid", int'(if_a.out_valid), 0);
    check("rst_count", int'(if_a.count), 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'hA);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    check("lat_early", int'(if_a.out_valid), 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    check("lat_q", int'(if_a.q), 10);
    check("lat_valid", int'(if_a.out_valid), 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);

    // Streaming 1..5, then drain.
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 1'b0, 1'b1, (k <= 5), (k <= 5) ? 4'(k) : 4'h0);
      check("str_count", int'(if_a.count), (k <= 3) ? k : ((k <= 5) ? 3 : 8 - k));
      check("str_valid", int'(if_a.out_valid), (k >= 3 && k <= 7) ? 1 : 0);
      if (k >= 3 && k <= 7) check("str_q", int'(if_a.q), k - 2);
    end

    // Stall: 6 and 7 loaded, 4 stalled cycles offering 9.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h6);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h7);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'h9);
      check("stall_count", int'(if_a.count), 2);
      check("stall_valid", int'(if_a.out_valid), 0);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    check("stall_q6", int'(if_a.q), 6);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    check("stall_q7", int'(if_a.q), 7);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    check("stall_drain", int'(if_a.out_valid), 0);

    // Flush a full pipe while offering a word.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'hB);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'hC);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'hD);
    check("full_count", int'(if_a.count), 3);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'hE);
    check("fl_count", int'(if_a.count), 0);
    check("fl_valid", int'(if_a.out_valid), 0);
    check("fl_qa", int'(if_a.q), 0);
    check("fl_qb", int'(if_b.q), 12);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);

    // Bubble between two words: gated vs raw view of the invalid slot.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h8);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h5);
    check("gate_q3a", int'(if_a.q), 3);
    check("gate_q3b", int'(if_b.q), 3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    check("gate_bub_a", int'(if_a.q), 8);
    check("gate_bub_b", int'(if_b.q), 12);
    check("gate_bub_v", int'(if_b.out_valid), 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    check("gate_q5a", int'(if_a.q), 5);
    check("gate_q5b", int'(if_b.q), 5);

    // Priority: reset+flush together, then flush with enable low.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h2);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'h4);
    check("rf_count", int'(if_a.count), 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h7);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'h8);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'h9);
    check("fl_en0_count", int'(if_a.count), 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(31) == 0),
            ($urandom_range(3) != 0), 1'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
Parametrised successor to the team's 4-bit enabled D flip-flop. It is a WIDTH-bit, DEPTH-stage register pipeline with a global advance enable, a per-word valid flag, a synchronous flush, and a live occupancy count. It is used as the standard delay/retiming element between datapath blocks where stalls (enable low) and pipeline flushes must be honoured.

Parameters:
- WIDTH, 4: data width in bits (>=1).
- DEPTH, 3: number of register stages, i.e. latency in enabled cycles (>=1).
- RESET_VALUE, 0: value loaded into every data stage on reset and flush (WIDTH bits).
- GATE_INVALID, 0: if 1, q is forced to RESET_VALUE whenever out_valid=0; if 0, q shows the raw last-stage data.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  advance enable; 1 = pipeline shifts one stage, 0 = all state holds.
- flush  input  1  synchronous clear of all stages (data and valid).
- in_valid  input  1  qualifies d.
- d  input  WIDTH  input data word.
- q  output  WIDTH  last-stage data.
- out_valid  output  1  last-stage valid flag.
- count  output  $clog2(DEPTH+1)  number of stages currently holding valid words (0..DEPTH).

Behaviour:
- State: data[0..DEPTH-1] (WIDTH each), valid[0..DEPTH-1], and a count register. Every output is registered or a direct function of the last stage; there is no combinational path from any input to any output.
- Priority on each rising edge: reset > flush > en > hold.
- reset=1: every data[i]=RESET_VALUE, every valid[i]=0, count=0. Consequently q=RESET_VALUE, out_valid=0, count=0 from the first edge with reset high. A reset asserted mid-operation discards all words in flight; no word is output afterwards.
- flush=1 (reset=0): identical clearing to reset, regardless of en. The word on d/in_valid in the same cycle is dropped.
- en=1 (reset=0, flush=0):
  - data[0]<=d and valid[0]<=in_valid.
  - data[i]<=data[i-1] and valid[i]<=valid[i-1] for i=1..DEPTH-1.
  - The word in the last stage is consumed (leaves the pipe).
- en=0: all data, valid and count hold. in_valid and d are ignored, and a word presented while en=0 is lost.
- Latency: a word accepted at edge k (en=1, in_valid=1) appears on q/out_valid after its DEPTH-th enabled edge. With en held high, it appears DEPTH cycles later. Stalled cycles add 1:1 to the latency.
- Invalid words (in_valid=0) still move their d value through the data stages; only valid marks them.
- count update on an en=1 edge: count <= count + in_valid - valid[DEPTH-1]. Simultaneous entry and exit leaves count unchanged. A full pipe with in_valid=1 stays at DEPTH. count never exceeds DEPTH and never goes below 0.
- Invariant: count equals the popcount of valid[] at all times. Verification checks this every cycle.
- DEPTH=1: degenerates to a single enabled register with a valid bit and count in {0,1}, matching the legacy DFF behaviour plus valid.
- X-safety: while en=0, d and in_valid may be X without corrupting state.

Test Plan:
- Reset: WIDTH=4, DEPTH=3, reset=1 for 2 cycles with d=4'hF, en=1, in_valid=1 -> q=0, out_valid=0, count=0. After release with d=4'hA, in_valid=1, en=1 -> q=4'hA and out_valid=1 at the 3rd edge after release.
- Streaming: en=1, in_valid=1, d=1,2,3,4,5 on consecutive cycles -> q=1,2,3,4,5 on cycles 3..7 with out_valid=1. count goes 1,2,3 and stays 3, then drains 2,1,0 after in_valid drops.
- Stall: load 4'h6 then 4'h7, drop en for 4 cycles with d=4'h9, in_valid=1 -> all outputs frozen and count=2. When en returns, 4'h6 exits first; 4'h9 is never output.
- Flush: pipe holding 3 valid words, assert flush with en=1 and in_valid=1 for 1 cycle -> next cycle count=0, out_valid=0, q=RESET_VALUE. No old word or the flush-cycle word ever appears.
- Bubbles and gating: GATE_INVALID=1, in_valid pattern 1,0,1 with d=3,8,5 -> q=3, then RESET_VALUE with out_valid=0, then 5. With GATE_INVALID=0 the middle cycle shows q=8 with out_valid=0.
- Priority: assert reset and flush together mid-stream, then flush alone with en=0 -> the pipe clears in both cases. The count-equals-popcount assertion holds throughout.
